// File: rtl/tail_light_sequencer_if.sv
// Switch-request / lamp-drive bundle between the input synchronizers and the sequencer.
interface tail_light_sequencer_if;
   logic       left;
   logic       right;
   logic       hazards;
   logic [5:0] lights;
   logic       busy;
   logic       step;

   modport master (output left, right, hazards, input lights, busy, step);
   modport slave  (input left, right, hazards, output lights, busy, step);
endinterface

// File: rtl/tail_light_sequencer.sv
// Tail-light sequencer: Moore FSM stepping turn/hazard lamp patterns at one step per DIV clocks.
module tail_light_sequencer #(
   parameter int DIV = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   tail_light_sequencer_if.slave  bus
);

   localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   typedef enum logic [3:0] {
      IDLE, L1, L2, L3, R1, R2, R3, OFF, HAZ_ON, HAZ_OFF
   } state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt;
   logic          tick;
   logic          hz;

   assign tick = (cnt == LAST) && (state != IDLE);
   // both turn switches together are treated as a hazard request
   assign hz   = bus.hazards | (bus.left & bus.right);

   function automatic state_t decide(input logic h, input logic l, input logic r);
      if (h)      return HAZ_ON;
      else if (l) return L1;
      else if (r) return R1;
      else        return IDLE;
   endfunction

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // prescaler keeps running across preemption so the new pattern stays on the step grid
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)             cnt <= '0;
      else if (state == IDLE) cnt <= '0;
      else if (cnt == LAST)   cnt <= '0;
      else                    cnt <= cnt + 1'b1;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = decide(hz, bus.left, bus.right);
         L1:      if (tick) state_nx = hz ? HAZ_ON : L2;
         L2:      if (tick) state_nx = hz ? HAZ_ON : L3;
         L3:      if (tick) state_nx = hz ? HAZ_ON : OFF;
         R1:      if (tick) state_nx = hz ? HAZ_ON : R2;
         R2:      if (tick) state_nx = hz ? HAZ_ON : R3;
         R3:      if (tick) state_nx = hz ? HAZ_ON : OFF;
         OFF,
         HAZ_OFF: if (tick) state_nx = decide(hz, bus.left, bus.right);
         HAZ_ON:  if (tick) state_nx = HAZ_OFF;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.lights = 6'b000000;
      case (state)
         L1:      bus.lights = 6'b001000;
         L2:      bus.lights = 6'b011000;
         L3:      bus.lights = 6'b111000;
         R1:      bus.lights = 6'b000100;
         R2:      bus.lights = 6'b000110;
         R3:      bus.lights = 6'b000111;
         HAZ_ON:  bus.lights = 6'b111111;
         default: bus.lights = 6'b000000;
      endcase
      bus.busy = (state != IDLE);
      bus.step = tick;
   end

endmodule
